mips_program_loader: RTL and testbench

- Boot-time stage that sits directly upstream of the multicycle von Neumann MIPS core and in front of the unified memory.
- Receives a byte stream (valid/ready), assembles little-endian 32-bit words, and writes them sequentially into memory.
- Holds the core in reset until the load completes, then hands the memory port to the core.
- Replaces testbench-side memory preloading for synthesizable boot.

---
 rtl/mips_program_loader.sv | 120 ++++++++++++
 tb/tb_mips_program_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to memory,
// holding the core in reset until the load finishes, then hands the memory port over.
module mips_program_loader #(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   BASE_ADDR = '0,
  parameter int unsigned    MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [N-1:0] cpu_mem_addr,
  input  logic [N-1:0] cpu_mem_wr_data,
  input  logic         cpu_mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  output logic         cpu_rst,
  output logic         cpu_ena,
  output logic         load_done,
  output logic         load_error,
  output logic [N-1:0] words_loaded
);

  typedef enum logic [2:0] {StCount, StData, StWrite, StDone, StError} state_e;

  state_e       state_q;
  logic [N-1:0] count_q;
  logic [N-1:0] word_idx_q;
  logic [N-1:0] word_q;
  logic [1:0]   byte_idx_q;

  logic [N-1:0] count_asm;
  logic [N-1:0] word_asm;
  logic [N-1:0] word_idx_inc;
  logic         rx_fire;

  // Candidate values with the incoming byte dropped into the current lane.
  always_comb begin
    count_asm = count_q;
    count_asm[{byte_idx_q, 3'b000} +: 8] = rx_data;
    word_asm = word_q;
    word_asm[{byte_idx_q, 3'b000} +: 8] = rx_data;
  end

  assign word_idx_inc = word_idx_q + 1'b1;
  assign rx_fire      = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= StCount;
      count_q    <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      case (state_q)
        StCount: begin
          if (rx_fire) begin
            count_q    <= count_asm;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              if (count_asm == '0) begin
                state_q <= StDone;
              end else if (count_asm > N'(MAX_WORDS)) begin
                state_q <= StError;
              end else begin
                state_q <= StData;
              end
            end
          end
        end
        StData: begin
          if (rx_fire) begin
            word_q     <= word_asm;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_inc;
          state_q    <= (word_idx_inc == count_q) ? StDone : StData;
        end
        default: ;
      endcase
    end
  end

  // Everything below depends only on registered state, so rx_valid never reaches rx_ready.
  always_comb begin
    rx_ready    = 1'b0;
    cpu_rst     = 1'b1;
    cpu_ena     = 1'b0;
    load_done   = 1'b0;
    load_error  = 1'b0;
    mem_addr    = BASE_ADDR + (word_idx_q << 2);
    mem_wr_data = word_q;
    mem_wr_ena  = 1'b0;
    case (state_q)
      StCount, StData: rx_ready = 1'b1;
      StWrite:         mem_wr_ena = 1'b1;
      StDone: begin
        load_done   = 1'b1;
        cpu_rst     = 1'b0;
        cpu_ena     = 1'b1;
        mem_addr    = cpu_mem_addr;
        mem_wr_data = cpu_mem_wr_data;
        mem_wr_ena  = cpu_mem_wr_ena;
      end
      StError:         load_error = 1'b1;
      default: ;
    endcase
  end

  assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected memory writes are queued by the stimulus and
// popped by a monitor whenever the loader asserts mem_wr_ena.
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wr_data;
  logic        cpu_mem_wr_ena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic        cpu_rst;
  logic        cpu_ena;
  logic        load_done;
  logic        load_error;
  logic [31:0] words_loaded;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  mips_program_loader dut (
    .clk             (clk),
    .rstb            (rstb),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .cpu_mem_addr    (cpu_mem_addr),
    .cpu_mem_wr_data (cpu_mem_wr_data),
    .cpu_mem_wr_ena  (cpu_mem_wr_ena),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ena      (mem_wr_ena),
    .cpu_rst         (cpu_rst),
    .cpu_ena         (cpu_ena),
    .load_done       (load_done),
    .load_error      (load_error),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: only loader-owned writes (core held in reset) are scoreboarded.
  always @(negedge clk) begin
    if (mem_wr_ena === 1'b1 && cpu_rst === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", mem_addr, mem_wr_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", mem_addr, exp_e[63:32]);
        check("wr_data", mem_wr_data, exp_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      stall_cnt++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", b, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_ena", cpu_ena, 0);
    check("rst_mem_wr_ena", mem_wr_ena, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wr_data", mem_wr_data, 32'h0);
    rstb = 1'b1;
  endtask

  logic [31:0] b2b_words [8] = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00000000,
                                 32'hFFFFFFFF, 32'h12345678, 32'hA5A55A5A, 32'h0F0F00F0};

  initial begin
    int bad;
    rstb            = 1'b0;
    rx_data         = 8'h00;
    rx_valid        = 1'b0;
    // Junk core traffic that must be ignored while the loader owns memory.
    cpu_mem_addr    = 32'hFFFF_FFF0;
    cpu_mem_wr_data = 32'h1357_9BDF;
    cpu_mem_wr_ena  = 1'b1;

    // Two-word load.
    do_reset();
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h2009000A});
    send_word(32'h2);
    send_word(32'h20080005);
    send_word(32'h2009000A);
    rx_valid = 1'b0;
    check("two_last_write_cpu_rst", cpu_rst, 1);
    @(posedge clk); #1;
    check("two_load_done", load_done, 1);
    check("two_words_loaded", words_loaded, 2);
    check("two_cpu_rst", cpu_rst, 0);
    check("two_cpu_ena", cpu_ena, 1);
    check("two_load_error", load_error, 0);
    check("two_queue_empty", exp_q.size(), 0);

    // Pass-through in the done state.
    cpu_mem_addr    = 32'h100;
    cpu_mem_wr_data = 32'hDEADBEEF;
    cpu_mem_wr_ena  = 1'b1;
    rx_valid        = 1'b1;
    rx_data         = 8'h77;
    #1;
    check("pt_mem_addr", mem_addr, 32'h100);
    check("pt_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
    check("pt_mem_wr_ena", mem_wr_ena, 1);
    check("pt_rx_ready", rx_ready, 0);
    @(posedge clk); #1;
    cpu_mem_addr   = 32'h200;
    cpu_mem_wr_ena = 1'b0;
    #1;
    check("pt_mem_addr2", mem_addr, 32'h200);
    check("pt_mem_wr_ena2", mem_wr_ena, 0);
    check("pt_load_done", load_done, 1);
    check("pt_words_loaded", words_loaded, 2);
    rx_valid        = 1'b0;
    cpu_mem_addr    = 32'hFFFF_FFF0;
    cpu_mem_wr_data = 32'h1357_9BDF;
    cpu_mem_wr_ena  = 1'b1;

    // Empty load.
    do_reset();
    send_word(32'h0);
    rx_valid = 1'b0;
    check("empty_load_done", load_done, 1);
    check("empty_cpu_ena", cpu_ena, 1);
    check("empty_words_loaded", words_loaded, 0);

    // Oversize count (1025).
    do_reset();
    send_word(32'h0000_0401);
    check("over_load_error", load_error, 1);
    check("over_load_done", load_done, 0);
    check("over_rx_ready", rx_ready, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cpu_rst !== 1'b1 || rx_ready !== 1'b0 || cpu_ena !== 1'b0) bad++;
    end
    check("over_hold_bad_cycles", bad, 0);
    check("over_words_loaded", words_loaded, 0);
    rx_valid = 1'b0;

    // Back-to-back stream of 8 words, rx_valid held high throughout.
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back({32'(i * 4), b2b_words[i]});
    stall_cnt = 0;
    send_word(32'h8);
    for (int i = 0; i < 8; i++) send_word(b2b_words[i]);
    rx_valid = 1'b0;
    check("b2b_stalls", stall_cnt, 7);
    @(posedge clk); #1;
    check("b2b_load_done", load_done, 1);
    check("b2b_words_loaded", words_loaded, 8);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Reset after half a data word, then a fresh single-word load.
    do_reset();
    send_word(32'h1);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    send_word(32'h1);
    send_word(32'hCAFEF00D);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_load_done", load_done, 1);
    check("mid_words_loaded", words_loaded, 1);
    check("mid_queue_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
